// File: rtl/emu_wrapper_gen.sv
// emu_wrapper_gen: co-emulation transactor between the 8-bit emulator bus
// and a DUT of arbitrary input/output width.  Stimulus bytes are staged and
// applied to dut_in on load.  step runs a burst of N generated DUT clocks and
// captures dut_out automatically at the end of the burst.
// Optional feature macro: EMU_CYCLE_COUNT_EN (16-bit dut_clk rising-edge
// counter, readable at Addr NUM_OUT+1 / NUM_OUT+2, cleared by a bus write
// to Addr NUM_OUT+1).
module emu_wrapper_gen #(
  parameter int IN_W     = 15,
  parameter int OUT_W    = 9,
  parameter int ADDR_W   = 3,
  parameter int HALF_PER = 2
) (
  input  logic              clk_emu,
  input  logic              rst_emu,
  input  logic [7:0]        Din_emu,
  output logic [7:0]        Dout_emu,
  input  logic [ADDR_W-1:0] Addr_emu,
  input  logic              load_emu,
  input  logic              get_emu,
  input  logic              step_emu,
  output logic              busy_emu,
  output logic              dut_clk,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out
);

  localparam int NUM_STIM = (IN_W + 7) / 8;
  localparam int NUM_OUT  = (OUT_W + 7) / 8;
  localparam int HC_W     = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_CAP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             burst_q, burst_d;
  logic [HC_W-1:0]        half_q, half_d;
  logic [IN_W-1:0]        stim_q, stim_d;
  logic [NUM_OUT*8-1:0]   cap_q, cap_d;
  logic [IN_W-1:0]        dut_in_q, dut_in_d;
  logic [7:0]             dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   dut_clk_q, dut_clk_d;
  logic [NUM_OUT*8-1:0]   cap_ext;
  logic                   idle;
  logic                   bus_en;
  logic                   half_done;
  logic [7:0]             rd_data;

`ifdef EMU_CYCLE_COUNT_EN
  logic [15:0]            cnt_q, cnt_d;
`endif

  assign idle      = (state_q == S_IDLE);
  // Commands only act in IDLE; while a burst runs the bus stays live.
  assign bus_en    = !idle || !(load_emu || get_emu || step_emu);
  assign half_done = (half_q == HC_W'(HALF_PER - 1));

  // Zero-extend dut_out to whole capture bytes.
  always_comb begin
    cap_ext              = '0;
    cap_ext[OUT_W-1:0]   = dut_out;
  end

  // Read mux: capture bytes, status, optional counter, else zero.
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (Addr_emu == ADDR_W'(k)) rd_data = cap_q[k*8 +: 8];
    end
    if (Addr_emu == ADDR_W'(NUM_OUT)) rd_data = {7'b0, busy_q};
`ifdef EMU_CYCLE_COUNT_EN
    if (Addr_emu == ADDR_W'(NUM_OUT + 1)) rd_data = cnt_q[7:0];
    if (Addr_emu == ADDR_W'(NUM_OUT + 2)) rd_data = cnt_q[15:8];
`endif
  end

  // Next-state: commands, burst FSM, bus access.
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    half_d   = half_q;
    stim_d   = stim_q;
    cap_d    = cap_q;
    dut_in_d = dut_in_q;
    dout_d   = dout_q;

    case (state_q)
      S_IDLE: begin
        if (load_emu) begin
          dut_in_d = stim_q;
        end else if (get_emu) begin
          cap_d = cap_ext;
        end else if (step_emu && (Din_emu != 8'h00)) begin
          burst_d = Din_emu;
          half_d  = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (half_done) begin
          half_d  = '0;
          state_d = S_LOW;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_LOW: begin
        if (half_done) begin
          half_d  = '0;
          burst_d = burst_q - 8'd1;
          state_d = (burst_q == 8'd1) ? S_CAP : S_HIGH;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_CAP: begin
        cap_d   = cap_ext;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus_en) begin
      // Byte k of the staged stimulus covers stim bits [8k+7:8k].
      for (int i = 0; i < IN_W; i++) begin
        if (Addr_emu == ADDR_W'(i / 8)) stim_d[i] = Din_emu[i % 8];
      end
      dout_d = rd_data;
    end
  end

  // dut_clk and busy follow the next state so both come straight from flops.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    dut_clk_d = (state_d == S_HIGH);
  end

`ifdef EMU_CYCLE_COUNT_EN
  // Count dut_clk rising edges; a bus write to the low byte clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (dut_clk_d && !dut_clk_q) cnt_d = cnt_q + 16'd1;
    if (bus_en && (Addr_emu == ADDR_W'(NUM_OUT + 1))) cnt_d = 16'd0;
  end

  // Counter register.
  always_ff @(posedge clk_emu) begin
    if (rst_emu) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end
`endif

  // State registers; reset aborts any burst on the same edge.
  always_ff @(posedge clk_emu) begin
    if (rst_emu) begin
      state_q   <= S_IDLE;
      burst_q   <= 8'd0;
      half_q    <= '0;
      stim_q    <= '0;
      cap_q     <= '0;
      dut_in_q  <= '0;
      dout_q    <= 8'd0;
      busy_q    <= 1'b0;
      dut_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      half_q    <= half_d;
      stim_q    <= stim_d;
      cap_q     <= cap_d;
      dut_in_q  <= dut_in_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      dut_clk_q <= dut_clk_d;
    end
  end

  assign Dout_emu = dout_q;
  assign busy_emu = busy_q;
  assign dut_clk  = dut_clk_q;
  assign dut_in   = dut_in_q;

endmodule

// File: tb/tb_emu_wrapper_gen.sv
// Scoreboard bench for emu_wrapper_gen: each stimulus cycle pushes the
// reference model's prediction; a monitor pops and compares after each edge.
module tb_emu_wrapper_gen;
  localparam int IN_W = 15, OUT_W = 9, ADDR_W = 3, HALF_PER = 2;
  localparam int NS = 2, NO = 2;

  logic              clk = 1'b0;
  logic              rst_emu = 1'b1;
  logic [7:0]        Din_emu = '0;
  logic [7:0]        Dout_emu;
  logic [ADDR_W-1:0] Addr_emu = '0;
  logic              load_emu = 1'b0, get_emu = 1'b0, step_emu = 1'b0;
  logic              busy_emu, dut_clk;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out = '0;

  always #5 clk = ~clk;

  emu_wrapper_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .HALF_PER(HALF_PER)) dut (
    .clk_emu(clk), .rst_emu(rst_emu), .Din_emu(Din_emu), .Dout_emu(Dout_emu),
    .Addr_emu(Addr_emu), .load_emu(load_emu), .get_emu(get_emu), .step_emu(step_emu),
    .busy_emu(busy_emu), .dut_clk(dut_clk), .dut_in(dut_in), .dut_out(dut_out));

  typedef struct {
    logic [7:0]      dout;
    logic            busy;
    logic            dclk;
    logic [IN_W-1:0] din;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a burst is a countdown of 2*HALF_PER*n+1 busy cycles;
  // dut_clk is derived from the position within the burst.
  logic [7:0]       m_stim [NS];
  logic [NO*8-1:0]  m_cap;
  logic [IN_W-1:0]  m_din;
  logic [7:0]       m_dout;
  int               m_rem, m_len;
  logic             m_clk;
  logic [15:0]      m_cnt;
  logic [OUT_W-1:0] dout_val = '0;

  task automatic model(input logic r, l, g, s, input logic [7:0] d, input int a);
    logic idle, bus, nclk;
    logic [7:0] rd;
    int t;
    if (r) begin
      for (int k = 0; k < NS; k++) m_stim[k] = 8'h00;
      m_cap = '0; m_din = '0; m_dout = '0; m_rem = 0; m_len = 0; m_clk = 0; m_cnt = '0;
      return;
    end
    idle = (m_rem == 0);
    bus  = !idle || !(l || g || s);
    rd = 8'h00;
    if (a < NO) rd = m_cap[a*8 +: 8];
    else if (a == NO) rd = (m_rem > 0) ? 8'h01 : 8'h00;
`ifdef EMU_CYCLE_COUNT_EN
    else if (a == NO + 1) rd = m_cnt[7:0];
    else if (a == NO + 2) rd = m_cnt[15:8];
`endif
    if (bus) m_dout = rd;
    if (!idle) begin
      if (m_rem == 1) begin m_cap = 16'(dout_val); m_rem = 0; end
      else m_rem--;
    end else if (l) m_din = IN_W'({m_stim[1], m_stim[0]});
    else if (g) m_cap = 16'(dout_val);
    else if (s && d != 0) begin m_len = 2 * HALF_PER * int'(d) + 1; m_rem = m_len; end
    t = m_len - m_rem;
    nclk = (m_rem > 0) && (t < m_len - 1) && ((t % (2 * HALF_PER)) < HALF_PER);
`ifdef EMU_CYCLE_COUNT_EN
    if (nclk && !m_clk) m_cnt++;
`endif
    m_clk = nclk;
    if (bus) begin
      if (a < NS) m_stim[a] = d;
`ifdef EMU_CYCLE_COUNT_EN
      if (a == NO + 1) m_cnt = '0;
`endif
    end
  endtask

  // One emulator cycle: drive at negedge, predict, push expectation.
  task automatic cyc(input logic r, l, g, s, input logic [7:0] d, input int a);
    exp_t e;
    @(negedge clk);
    rst_emu = r; load_emu = l; get_emu = g; step_emu = s;
    Din_emu = d; Addr_emu = a[ADDR_W-1:0]; dut_out = dout_val;
    model(r, l, g, s, d, a);
    e.dout = m_dout; e.busy = (m_rem > 0); e.dclk = m_clk; e.din = m_din;
    sb.push_back(e);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 8'h00, NO);
  endtask

  task automatic wait_done(input int lim);
    int g = 0;
    while (m_rem > 0 && g < lim) begin idle_cyc(); g++; end
    chk("burst_timeout", m_rem, 0);
  endtask

  // Monitor: compare every DUT output against the oldest prediction.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_dout", Dout_emu, e.dout);
      chk("sb_busy", busy_emu, e.busy);
      chk("sb_dut_clk", dut_clk, e.dclk);
      chk("sb_dut_in", dut_in, e.din);
    end
  end

  initial begin
    int bcnt, hi, rise, guard;
    logic prev, any_clk;

    // Reset and read every address.
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) cyc(0, 0, 0, 0, 8'h00, a);
    idle_cyc();
    @(posedge clk); #2;
    chk("rst_busy", busy_emu, 0); chk("rst_dut_clk", dut_clk, 0); chk("rst_dut_in", dut_in, 0);

    // Stage and load stimulus; a later write without load leaves dut_in alone.
    cyc(0, 0, 0, 0, 8'hA5, 0);
    cyc(0, 0, 0, 0, 8'hFF, 1);
    cyc(0, 1, 0, 0, 8'h00, NO);
    cyc(0, 0, 0, 0, 8'h11, 0);
    @(posedge clk); #2;
    chk("load_dut_in", dut_in, 15'h7FA5);

    // Burst of 3: busy 13 cycles, 3 pulses each 2 cycles high.
    dout_val = 9'h1C3;
    cyc(0, 0, 0, 1, 8'd3, NO);
    @(posedge clk); #2;
    bcnt = 0; hi = 0; rise = 0; prev = 0; guard = 0;
    while (busy_emu && guard < 100) begin
      bcnt++;
      if (dut_clk) hi++;
      if (dut_clk && !prev) rise++;
      prev = dut_clk;
      idle_cyc();
      @(posedge clk); #2;
      guard++;
    end
    chk("busy_len", bcnt, 13); chk("clk_high_cycles", hi, 6); chk("clk_pulses", rise, 3);
    cyc(0, 0, 0, 0, 8'h11, 0);
    @(posedge clk); #2; chk("cap_byte0", Dout_emu, 8'hC3);
    cyc(0, 0, 0, 0, 8'hFF, 1);
    @(posedge clk); #2; chk("cap_byte1", Dout_emu, 8'h01);

    // Commands ignored during a burst; bus stays live.
    cyc(0, 0, 0, 1, 8'd2, NO);
    cyc(0, 0, 0, 0, 8'h22, 0);
    dout_val = 9'h055;
    cyc(0, 1, 0, 0, 8'h00, NO);
    cyc(0, 0, 1, 0, 8'h00, NO);
    cyc(0, 0, 0, 0, 8'h00, 0);
    @(posedge clk); #2;
    chk("busy_load_ignored", dut_in, 15'h7FA5);
    chk("busy_get_ignored", Dout_emu, 8'hC3);
    cyc(0, 0, 0, 0, 8'h00, NO);
    @(posedge clk); #2; chk("status_busy", Dout_emu, 8'h01);
    dout_val = 9'h1C3;
    wait_done(50);
    idle_cyc();
    @(posedge clk); #2; chk("status_idle", Dout_emu, 8'h00);

    // Reset in the second HIGH phase of a 5-clock burst.
    cyc(0, 0, 0, 1, 8'd5, NO);
    for (int i = 0; i < 2 * HALF_PER; i++) idle_cyc();
    cyc(1, 0, 0, 0, 8'h00, NO);
    @(posedge clk); #2;
    chk("abort_dut_clk", dut_clk, 0); chk("abort_busy", busy_emu, 0);
    cyc(0, 0, 0, 0, 8'h00, 0);
    @(posedge clk); #2; chk("abort_cap0", Dout_emu, 8'h00);
    cyc(0, 0, 0, 1, 8'h00, NO);
    any_clk = 0;
    for (int i = 0; i < 6; i++) begin
      idle_cyc(); @(posedge clk); #2;
      if (dut_clk || busy_emu) any_clk = 1;
    end
    chk("step_zero_noop", any_clk, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      int op;
      op = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) dout_val = OUT_W'($urandom_range(0, 511));
      if (op < 1)       cyc(1, 0, 0, 0, 8'h00, NO);
      else if (op < 10) cyc(0, 1, 0, 0, 8'($urandom), $urandom_range(0, 7));
      else if (op < 18) cyc(0, 0, 1, 0, 8'($urandom), $urandom_range(0, 7));
      else if (op < 28) cyc(0, 0, 0, 1, 8'($urandom_range(0, 3)), $urandom_range(0, 7));
      else              cyc(0, 0, 0, 0, 8'($urandom), $urandom_range(0, 7));
    end
    wait_done(100);

`ifdef EMU_CYCLE_COUNT_EN
    cyc(1, 0, 0, 0, 8'h00, NO);
    cyc(0, 0, 0, 1, 8'd255, NO); wait_done(2000);
    cyc(0, 0, 0, 1, 8'd2, NO);   wait_done(100);
    cyc(0, 0, 0, 0, 8'h00, NO + 2);
    @(posedge clk); #2; chk("cnt_hi", Dout_emu, 8'h01);
    cyc(0, 0, 0, 0, 8'h00, NO + 1);
    @(posedge clk); #2; chk("cnt_lo", Dout_emu, 8'h01);
    cyc(0, 0, 0, 0, 8'h00, NO + 2);
    @(posedge clk); #2; chk("cnt_cleared", Dout_emu, 8'h00);
`endif

    idle_cyc();
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/emu_wrapper_gen.md
Name: emu_wrapper_gen

Overview:
- Parametrised co-emulation transactor between the 8-bit emulator bus and a DUT of arbitrary input and output width.
- Stages stimulus bytes, applies them to the DUT, and generates a burst of N DUT clocks from the emulator clock.
- Captures DUT outputs automatically at the end of each burst and exposes capture data, status and an optional cycle counter on the read bus.
- Replaces fixed per-design wrappers that pass an external DUT clock straight through.

Parameters:
- IN_W, 15: DUT input width in bits. NUM_STIM = ceil(IN_W/8) stimulus bytes.
- OUT_W, 9: DUT output width in bits. NUM_OUT = ceil(OUT_W/8) capture bytes.
- ADDR_W, 3: emulator address width. Requires 2^ADDR_W >= max(NUM_STIM, NUM_OUT+3).
- HALF_PER, 2: clk_emu cycles per DUT clock half-period, >= 1.

Ports:
- clk_emu  in  1  emulator clock; single clock domain.
- rst_emu  in  1  synchronous, active-high reset.
- Din_emu  in  8  write data; burst length when step_emu is high.
- Dout_emu  out  8  registered read data.
- Addr_emu  in  ADDR_W  byte address.
- load_emu  in  1  apply staged stimulus to dut_in.
- get_emu  in  1  manual capture of dut_out.
- step_emu  in  1  start a DUT clock burst of Din_emu cycles.
- busy_emu  out  1  high while a burst runs.
- dut_clk  out  1  generated DUT clock.
- dut_in  out  IN_W  registered DUT inputs.
- dut_out  in  OUT_W  DUT outputs.

Behaviour:
- Reset values: stim bytes 0, capture bytes 0, dut_in 0, dut_clk 0, busy_emu 0, Dout_emu 0, FSM IDLE, burst and half counters 0. Reset mid-burst aborts immediately: dut_clk is 0 on the next edge and no capture occurs.
- Command priority per clk_emu edge: rst_emu > load_emu > get_emu > step_emu > bus access.
- Bus access (no command asserted):
  - Write stim[Addr] <= Din_emu when Addr < NUM_STIM; otherwise ignored.
  - Read (1-cycle latency) Dout_emu <= cap[Addr] when Addr < NUM_OUT.
  - Addr == NUM_OUT reads status {7'b0, busy_emu}.
  - Any other address reads 0.
- load: dut_in <= packed stim. Byte k drives dut_in[8k+7:8k]; bits at or above IN_W are dropped.
- Capture packing: dut_out is zero-extended to NUM_OUT*8 bits; byte k goes to cap[k]. Unused high bits read 0.
- While busy_emu = 1:
  - load_emu, get_emu and step_emu are ignored.
  - Bus reads are still served.
  - Stim writes are still accepted (no effect on dut_in until the next load).
- step_emu with Din_emu == 0 is a no-op; the FSM stays in IDLE.
- FSM states:
  - IDLE: step_emu with Din_emu != 0 latches the burst count n = Din_emu, sets busy_emu = 1 and moves to HIGH.
  - HIGH: dut_clk = 1 for HALF_PER cycles, then LOW.
  - LOW: dut_clk = 0 for HALF_PER cycles. Decrement n; if n becomes 0 go to CAP, else go to HIGH.
  - CAP: one cycle; cap <= dut_out; busy_emu cleared on leaving. Then IDLE.
- Timing: a burst of n clocks keeps busy_emu high for exactly 2*HALF_PER*n + 1 cycles. The first dut_clk rising edge is visible 1 cycle after the step_emu edge.
- dut_clk is a register output, glitch-free, and always 0 in IDLE and CAP.
- get_emu performs the same capture as CAP, immediately, in IDLE only.

Optional Feature:
- Macro: EMU_CYCLE_COUNT_EN.
- Defined:
  - A 16-bit counter increments on every cycle in which dut_clk goes 0->1, and wraps 0xFFFF -> 0.
  - Cleared by rst_emu.
  - Also cleared by a write to Addr NUM_OUT+1 (data ignored).
  - Readable: Addr NUM_OUT+1 returns bits [7:0]; Addr NUM_OUT+2 returns bits [15:8].
- Undefined: no counter logic; those addresses read 0 and writes to them are ignored.

Test Plan:
- Reset, then read every address -> all 0. busy_emu = 0, dut_clk = 0, dut_in = 0.
- IN_W=15: write stim0=0xA5, stim1=0xFF, then load -> dut_in = 15'h7FA5. Write stim0=0x11 without load -> dut_in unchanged.
- dut_out=9'h1C3, HALF_PER=2, step with Din_emu=3:
  - busy_emu high for exactly 13 cycles, with 3 dut_clk pulses each 2 cycles high.
  - Read Addr0 -> 0xC3, Addr1 -> 0x01.
- During a burst, assert load and get with changed stim and dut_out -> dut_in and capture unchanged. Status read returns 0x01; after the burst it returns 0x00.
- Assert rst_emu in the 2nd HIGH phase of a 5-clock burst -> next cycle dut_clk = 0, busy_emu = 0, cap = 0. step with Din_emu=0 -> no dut_clk activity.
- EMU_CYCLE_COUNT_EN: bursts of 255 and 2 -> count 0x0101. Write Addr NUM_OUT+1 -> count 0. Preload 0xFFFF via 65535 pulses, then 1 more pulse -> 0x0000.
